// File: rtl/hazard_unit.sv
// Purpose : pipeline hazard controller (forwarding selects, F/D stalls, D/E flushes) for the 5-stage core.
// Latency : all outputs combinational; PC-write-pending carried M->W in two internal flops.
// Backpr. : no handshake; StallF/StallD hold the front end, FlushD/FlushE insert bubbles.
// Ports   : clk, reset (async, active-low); RA1D/RA2D, RA1E/RA2E source regs; WA3E/M/W dest regs;
//           RegWriteE/M/W, MemtoRegE, PCSD, PCSrcE, BranchTakenE in; ForwardAE/BE, StallF/D, FlushD/E out.
// Config  : FORWARD_EN defined -> E-stage forwarding with load-use stall only;
//           undefined -> no forwarding, RAW stall against E and M writers.
module hazard_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] RA1D,
   input  logic [3:0] RA2D,
   input  logic [3:0] RA1E,
   input  logic [3:0] RA2E,
   input  logic [3:0] WA3E,
   input  logic [3:0] WA3M,
   input  logic [3:0] WA3W,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       PCSD,
   input  logic       PCSrcE,
   input  logic       BranchTakenE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE
);

   // PC-write pending, tracked locally so M and W need not export it.
   logic pcsrc_m;
   logic pcsrc_w;
   logic pend;
   logic data_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcsrc_m <= 1'b0;
         pcsrc_w <= 1'b0;
      end else begin
         pcsrc_m <= PCSrcE;
         pcsrc_w <= pcsrc_m;
      end
   end

   // R15 reads come from the PC path, never from a bypass or a stall.
   function automatic logic reg_match(input logic [3:0] ra, input logic [3:0] wa);
      return (ra == wa) && (ra != 4'd15);
   endfunction

`ifdef FORWARD_EN
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
      if (RegWriteM && reg_match(ra, WA3M))
         return 2'b10;
      else if (RegWriteW && reg_match(ra, WA3W))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign ForwardAE  = fwd_sel(RA1E);
   assign ForwardBE  = fwd_sel(RA2E);
   // Only a load in E cannot be bypassed in time for the dependent op in D.
   assign data_stall = MemtoRegE & RegWriteE &
                       (reg_match(RA1D, WA3E) | reg_match(RA2D, WA3E));
`else
   // W writers are safe: the register file writes on the falling edge.
   logic unused_fwd;
   assign unused_fwd = ^{RA1E, RA2E, WA3W, RegWriteW, MemtoRegE};

   assign ForwardAE  = 2'b00;
   assign ForwardBE  = 2'b00;
   assign data_stall = (RegWriteE & (reg_match(RA1D, WA3E) | reg_match(RA2D, WA3E))) |
                       (RegWriteM & (reg_match(RA1D, WA3M) | reg_match(RA2D, WA3M)));
`endif

   assign pend   = PCSD | PCSrcE | pcsrc_m;
   assign StallF = data_stall | pend;
   assign StallD = data_stall;
   assign FlushE = data_stall | BranchTakenE;
   // When FlushD and StallD coincide, the F->D register must let the flush win.
   assign FlushD = pend | pcsrc_w | BranchTakenE;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
   logic       PCSD, PCSrcE, BranchTakenE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE;

   int n_checks = 0;
   int n_fails  = 0;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .PCSD(PCSD), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
   );

   // Observed vector: {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
   task automatic chk(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b, expected FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b",
                tag, obs[7:6], obs[5:4], obs[3], obs[2], obs[1], obs[0],
                exp[7:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic clear_inputs();
      RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
      WA3E = 0; WA3M = 0; WA3W = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
      PCSD = 0; PCSrcE = 0; BranchTakenE = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      #2;
      chk("reset_state", 8'b0000_0000);

      @(negedge clk);
      reset = 1'b1;
      next_cycle();
      chk("after_release", 8'b0000_0000);

      // Forwarding priority: M over W, R15 never forwards.
      RA1E = 3; RA2E = 3;
      RegWriteM = 1; WA3M = 3;
      RegWriteW = 1; WA3W = 3;
      #1 chk("fwd_m_priority", FWD ? 8'b1010_0000 : 8'b0000_0000);
      RegWriteM = 0;
      #1 chk("fwd_w_only", FWD ? 8'b0101_0000 : 8'b0000_0000);
      RA1E = 15;
      #1 chk("fwd_r15_a", FWD ? 8'b0001_0000 : 8'b0000_0000);
      RegWriteM = 1; WA3M = 15; WA3W = 15; RA2E = 15;
      #1 chk("fwd_r15_both", 8'b0000_0000);
      RA2E = 7; WA3M = 9; WA3W = 7;
      #1 chk("fwd_b_w_split", FWD ? 8'b0001_0000 : 8'b0000_0000);
      clear_inputs();

      // Load-use stall for exactly one cycle.
      next_cycle();
      MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
      #1 chk("load_use", 8'b0000_1101);
      next_cycle();
      clear_inputs();
      #1 chk("load_use_gone", 8'b0000_0000);

      // Load to R15 does not stall a reader of R15.
      MemtoRegE = 1; RegWriteE = 1; WA3E = 15; RA1D = 15;
      #1 chk("load_use_r15", 8'b0000_0000);
      clear_inputs();

      // Taken branch together with load-use.
      MemtoRegE = 1; RegWriteE = 1; WA3E = 6; RA1D = 6; BranchTakenE = 1;
      #1 chk("branch_load_use", 8'b0000_1111);
      clear_inputs();
      BranchTakenE = 1;
      #1 chk("branch_only", 8'b0000_0011);
      clear_inputs();

      // PC write in D, then in E, then drains through M and W.
      next_cycle();
      PCSD = 1;
      #1 chk("pc_t0_D", 8'b0000_1010);
      next_cycle();
      PCSD = 0; PCSrcE = 1;
      #1 chk("pc_t1_E", 8'b0000_1010);
      next_cycle();
      PCSrcE = 0;
      #1 chk("pc_t2_M", 8'b0000_1010);
      next_cycle();
      chk("pc_t3_W", 8'b0000_0010);
      next_cycle();
      chk("pc_t4_done", 8'b0000_0000);

      // Reset one cycle after PCSrcE clears the pending state at once.
      PCSrcE = 1;
      next_cycle();
      PCSrcE = 0;
      #1 chk("pre_reset_pend", 8'b0000_1010);
      reset = 1'b0;
      #1 chk("reset_mid_seq", 8'b0000_0000);
      next_cycle();
      chk("held_in_reset", 8'b0000_0000);
      @(negedge clk);
      reset = 1'b1;
      next_cycle();
      chk("post_reset_1", 8'b0000_0000);
      next_cycle();
      chk("post_reset_2", 8'b0000_0000);

      // RAW dependency on an M writer: stalls only without forwarding.
      RegWriteM = 1; WA3M = 2; RA1D = 2;
      #1 chk("raw_m", FWD ? 8'b0000_0000 : 8'b0000_1101);
      RegWriteM = 0; WA3M = 0; RegWriteW = 1; WA3W = 2;
      #1 chk("raw_w_only", 8'b0000_0000);
      clear_inputs();
      RegWriteE = 1; WA3E = 4; RA2D = 4;
      #1 chk("raw_e_alu", FWD ? 8'b0000_0000 : 8'b0000_1101);
      clear_inputs();

      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, observed time limit reached, required normal finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage conditional-execution core. It sits opposite the execute-stage condition unit: it consumes that unit's qualified outputs (PCSrcE, BranchTakenE) and the register-address and write-enable bundles of every stage. It drives forwarding selects, fetch/decode stalls and decode/execute flushes. It also carries the PC-write-pending state from M to W in internal registers, so no other pipeline stage has to export it.

## Interface
- No parameters. Register addresses are fixed at 4 bits; R15 is the PC.
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous reset, active-low: the unit is held in reset while reset=0
- RA1D, RA2D  input  4  source registers of the instruction in D
- RA1E, RA2E  input  4  source registers of the instruction in E
- WA3E, WA3M, WA3W  input  4  destination registers in E, M and W
- RegWriteE, RegWriteM, RegWriteW  input  1  qualified register-write enables per stage
- MemtoRegE  input  1  the instruction in E is a load
- PCSD  input  1  the instruction in D writes the PC (unqualified)
- PCSrcE  input  1  PC write in E, qualified by CondEx
- BranchTakenE  input  1  branch taken in E, qualified by CondEx
- ForwardAE, ForwardBE  output  2  ALU operand select: 00 regfile, 01 ResultW, 10 ALUResultM
- StallF, StallD  output  1  hold the PC register / hold the F→D register
- FlushD, FlushE  output  1  bubble the F→D register / bubble the D→E register

## Operation
- Internal state:
  - pcsrc_m: registered PCSrcE.
  - pcsrc_w: registered pcsrc_m.
  - Both update every cycle. The E→M and M→W registers are never stalled or flushed by this unit.
- Forwarding (with FORWARD_EN), for operand A; operand B is identical using RA2E:
  - ForwardAE=10 if RegWriteM and RA1E==WA3M.
  - Otherwise ForwardAE=01 if RegWriteW and RA1E==WA3W.
  - Otherwise ForwardAE=00.
  - The M match has priority over the W match.
  - RA==15 never forwards. The result is 00 even when the address matches.
- Load-use stall: ldrStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E), excluding RA==15.
- PC-write pending: pend = PCSD | PCSrcE | pcsrc_m.
- Output equations:
  - StallF = ldrStall | pend
  - StallD = ldrStall
  - FlushE = ldrStall | BranchTakenE
  - FlushD = pend | pcsrc_w | BranchTakenE
- Simultaneous events:
  - ldrStall with BranchTakenE: FlushE=1, StallD=1, FlushD=1. The flush of D wins over its stall; the pipeline register must give flush priority.
  - ldrStall with pend: both stalls assert and FlushD=1.

## Timing
- All outputs are combinational functions of the inputs and the two internal registers. There is no added latency.
- pcsrc_m follows PCSrcE with 1-cycle latency; pcsrc_w follows it with 2-cycle latency.
- A PC-writing instruction observed in D at cycle t produces, assuming no other hazards:
  - StallF high for cycles t..t+2 (D, E, M).
  - FlushD high for cycles t..t+3.
  - At t+4 both are low again.
- Reset, asserted at any time including in the middle of a pending-PC sequence:
  - pcsrc_m=0 and pcsrc_w=0 immediately (asynchronous).
  - With all data inputs at 0, every output is 0. With all-zero addresses and enables, ForwardAE/BE=00.
- Release of reset is synchronized externally. The state is updated on the first rising edge with reset=1.

## Configuration
- FORWARD_EN defined (default build):
  - Forwarding is as described above.
  - Only the load-use stall is generated.
- FORWARD_EN undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - ldrStall is replaced by a RAW stall: (RegWriteE & WA3E matches RA1D or RA2D) | (RegWriteM & WA3M matches RA1D or RA2D), excluding R15.
  - W-stage writes are not a hazard, because the register file writes on the falling edge.
  - FlushE = rawStall | BranchTakenE. The PC-pending logic is unchanged.

## Test plan
- Forwarding priority: RA1E=3; RegWriteM=1, WA3M=3; RegWriteW=1, WA3W=3 -> ForwardAE=10. Then drop RegWriteM -> ForwardAE=01. Set RA1E=15 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1, FlushD=0 for exactly that cycle.
- PC write: PCSD=1 for 1 cycle, then PCSrcE=1 for 1 cycle, then both 0 -> StallF pattern 1,1,1,0 and FlushD pattern 1,1,1,1,0.
- Taken branch coinciding with load-use: BranchTakenE=1 with ldrStall true -> FlushD=1, FlushE=1, StallD=1.
- Reset mid-sequence: pull reset low one cycle after PCSrcE=1 -> StallF and FlushD drop to 0 within the same cycle (inputs zeroed), and stay 0 after release.
- FORWARD_EN undefined: RegWriteM=1, WA3M=2, RA1D=2 -> StallF=1, StallD=1, FlushE=1, ForwardAE=00. Same case with the match only in W -> no stall.
